// File: rtl/lcd_write_queue.sv
// Byte FIFO between the LCD opcode decode and the LCD driver, draining one byte per
// write/ready handshake. Define LCDQ_DROPCNT_EN to add the oDropCount overflow counter.
module lcd_write_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iWrite,
  input  logic [DATA_W-1:0]     iData,
  input  logic                  iFlush,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic [DEPTH_LOG2:0]   oLevel,
  output logic                  oIdle,
`ifdef LCDQ_DROPCNT_EN
  output logic [7:0]            oDropCount,
`endif
  input  logic                  iLCDInitialized,
  input  logic                  iLCDReady,
  output logic                  oLCDWrite,
  output logic [DATA_W-1:0]     oLCDData
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_DROP,
    S_WAIT_RISE
  } state_t;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [1:0]          drop_timer;
  state_t              state;
  logic                push;
  logic                pop;
  logic                can_start;

  assign oEmpty = (wr_ptr == rd_ptr);
  assign oFull  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign oLevel = wr_ptr - rd_ptr;
  assign oIdle  = oEmpty && (state == S_IDLE);

  // Flush wins over both sides: the push is discarded and LOAD falls back to IDLE.
  assign push      = iWrite && !oFull && !iFlush;
  assign pop       = (state == S_LOAD) && !oEmpty && !iFlush;
  assign can_start = iLCDInitialized && !oEmpty && !iFlush;

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= iData;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (iFlush)   rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      oLCDWrite  <= 1'b0;
      oLCDData   <= '0;
      drop_timer <= '0;
    end else begin
      oLCDWrite <= 1'b0;
      case (state)
        S_IDLE:
          if (can_start) state <= S_LOAD;
        S_LOAD:
          if (pop) begin
            oLCDData <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            state    <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        S_ISSUE:
          if (iLCDReady && iLCDInitialized) begin
            oLCDWrite  <= 1'b1;
            drop_timer <= '0;
            state      <= S_WAIT_DROP;
          end
        // A driver that never drops ready is treated as having accepted after 4 cycles.
        S_WAIT_DROP:
          if (!iLCDReady || drop_timer == 2'd3) state <= S_WAIT_RISE;
          else                                 drop_timer <= drop_timer + 1'b1;
        S_WAIT_RISE:
          if (iLCDReady) state <= can_start ? S_LOAD : S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

`ifdef LCDQ_DROPCNT_EN
  always_ff @(posedge Clock) begin
    if (Reset)
      oDropCount <= '0;
    else if (iWrite && oFull && !iFlush && oDropCount != 8'hFF)
      oDropCount <= oDropCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_lcd_write_queue.sv
// Randomized self-checking bench for lcd_write_queue: a byte queue reference model plus a
// simple LCD driver model that drops ready after each strobe.
module tb_lcd_write_queue;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iWrite;
  logic [7:0] iData;
  logic       iFlush;
  logic       oFull;
  logic       oEmpty;
  logic [4:0] oLevel;
  logic       oIdle;
  logic       iLCDInitialized;
  logic       iLCDReady;
  logic       oLCDWrite;
  logic [7:0] oLCDData;
`ifdef LCDQ_DROPCNT_EN
  logic [7:0] oDropCount;
`endif

  lcd_write_queue #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iWrite(iWrite),
    .iData(iData),
    .iFlush(iFlush),
    .oFull(oFull),
    .oEmpty(oEmpty),
    .oLevel(oLevel),
    .oIdle(oIdle),
`ifdef LCDQ_DROPCNT_EN
    .oDropCount(oDropCount),
`endif
    .iLCDInitialized(iLCDInitialized),
    .iLCDReady(iLCDReady),
    .oLCDWrite(oLCDWrite),
    .oLCDData(oLCDData)
  );

  always #5 Clock = ~Clock;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes the queue has accepted and still owes the driver, in order.
  logic [7:0]  exp_q[$];
  int unsigned strobes = 0;
  logic        prev_wr = 1'b0;

  always @(negedge Clock) begin
    if (oLCDWrite) begin
      strobes++;
      check("strobe_back_to_back", {31'd0, prev_wr}, 32'd0);
      check("strobe_while_uninit", {31'd0, iLCDInitialized}, 32'd1);
      if (exp_q.size() == 0) check("unexpected_strobe", exp_q.size(), 32'd1);
      else                   check("strobe_data", {24'd0, oLCDData}, {24'd0, exp_q.pop_front()});
    end
    prev_wr = oLCDWrite;
  end

  // Driver model: ready falls right after the strobe and stays low 1..drv_maxlow cycles.
  logic        drv_never = 1'b0;
  logic        drv_hold  = 1'b0;
  int unsigned drv_low   = 0;
  int unsigned drv_maxlow = 1;

  always @(negedge Clock) begin
    if (drv_low > 0)                    drv_low--;
    else if (oLCDWrite && !drv_never)   drv_low = $urandom_range(drv_maxlow, 1);
    iLCDReady = !(drv_hold || drv_low > 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push(input logic [7:0] d, input bit accept);
    iWrite = 1'b1;
    iData  = d;
    if (accept) exp_q.push_back(d);
    @(negedge Clock);
    iWrite = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      if (oIdle && exp_q.size() == 0 && iLCDReady) break;
      @(negedge Clock);
    end
    check(tag, {31'd0, (k < 400)}, 32'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge Clock);
      if (oLCDWrite) break;
    end
    check(tag, {31'd0, (k < 30)}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          k;
    int unsigned s0;
    int unsigned pushed;
    int unsigned cyc;

    Reset = 1'b1; iWrite = 1'b0; iData = '0; iFlush = 1'b0; iLCDInitialized = 1'b0;
    tick(3);
    check("rst_empty", {31'd0, oEmpty}, 32'd1);
    check("rst_full",  {31'd0, oFull},  32'd0);
    check("rst_level", {27'd0, oLevel}, 32'd0);
    check("rst_idle",  {31'd0, oIdle},  32'd1);
    check("rst_write", {31'd0, oLCDWrite}, 32'd0);
    check("rst_data",  {24'd0, oLCDData},  32'd0);
`ifdef LCDQ_DROPCNT_EN
    check("rst_dropcnt", {24'd0, oDropCount}, 32'd0);
`endif
    Reset = 1'b0;

    // T1: single byte latency
    iLCDInitialized = 1'b1;
    tick(2);
    s0 = strobes;
    push(8'h41, 1'b1);
    for (k = 1; k <= 10; k++) begin
      @(negedge Clock);
      if (oLCDWrite) break;
    end
    check("t1_latency", k, 32'd3);
    check("t1_data", {24'd0, oLCDData}, 32'h41);
    drain("t1_drain");
    check("t1_strobes", strobes - s0, 32'd1);
    check("t1_idle", {31'd0, oIdle}, 32'd1);

    // T2: fill while uninitialized, overflow drop, then drain in order
    iLCDInitialized = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), 1'b1);
    check("t2_full",  {31'd0, oFull},  32'd1);
    check("t2_level", {27'd0, oLevel}, 32'd16);
    check("t2_empty", {31'd0, oEmpty}, 32'd0);
    push(8'h40, 1'b0);
    check("t2_level_after_drop", {27'd0, oLevel}, 32'd16);
`ifdef LCDQ_DROPCNT_EN
    check("t2_dropcnt", {24'd0, oDropCount}, 32'd1);
`endif
    tick(5);
    check("t2_no_strobe", strobes - s0, 32'd0);
    iLCDInitialized = 1'b1;
    drain("t2_drain");
    check("t2_strobes", strobes - s0, 32'd16);

    // T3: push+pop while full, then at level 5
    iLCDInitialized = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h50 + 8'(i), 1'b1);
    iLCDInitialized = 1'b1;
    @(negedge Clock);
    push(8'h99, 1'b0);
    check("t3_full_pushpop_level", {27'd0, oLevel}, 32'd15);
    check("t3_full_pushpop_full",  {31'd0, oFull},  32'd0);
`ifdef LCDQ_DROPCNT_EN
    check("t3_dropcnt", {24'd0, oDropCount}, 32'd2);
`endif
    drain("t3_drain_full");
    iLCDInitialized = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1);
    iLCDInitialized = 1'b1;
    @(negedge Clock);
    push(8'h77, 1'b1);
    check("t3_level5_pushpop", {27'd0, oLevel}, 32'd5);
    drain("t3_drain_5");

    // T4: flush while the first byte is waiting for ready to drop
    iLCDInitialized = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b1);
    s0 = strobes;
    iLCDInitialized = 1'b1;
    wait_strobe("t4_first_strobe");
    iFlush = 1'b1;
    #1 exp_q.delete();
    @(negedge Clock);
    iFlush = 1'b0;
    check("t4_empty", {31'd0, oEmpty}, 32'd1);
    check("t4_level", {27'd0, oLevel}, 32'd0);
    tick(20);
    check("t4_strobes", strobes - s0, 32'd1);
    check("t4_idle", {31'd0, oIdle}, 32'd1);

    // T5a: driver never drops ready -> 4-cycle timeout, then WAIT_RISE, LOAD, ISSUE
    iLCDInitialized = 1'b0;
    drv_never = 1'b1;
    push(8'h81, 1'b1);
    push(8'h82, 1'b1);
    iLCDInitialized = 1'b1;
    wait_strobe("t5_first_strobe");
    for (k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (oLCDWrite) break;
    end
    check("t5_timeout_gap", k, 32'd7);
    drain("t5_drain");
    drv_never = 1'b0;

    // T5b: reset while stuck in ISSUE abandons everything
    drv_hold = 1'b1;
    tick(2);
    push(8'h91, 1'b0);
    push(8'h92, 1'b0);
    push(8'h93, 1'b0);
    tick(3);
    check("t5_level_in_issue", {27'd0, oLevel}, 32'd2);
    Reset = 1'b1;
    @(negedge Clock);
    check("t5_rst_write", {31'd0, oLCDWrite}, 32'd0);
    check("t5_rst_level", {27'd0, oLevel}, 32'd0);
    check("t5_rst_empty", {31'd0, oEmpty}, 32'd1);
`ifdef LCDQ_DROPCNT_EN
    check("t5_rst_dropcnt", {24'd0, oDropCount}, 32'd0);
`endif
    Reset = 1'b0;
    drv_hold = 1'b0;
    s0 = strobes;
    tick(20);
    check("t5_no_strobe_after_rst", strobes - s0, 32'd0);
    check("t5_idle_after_rst", {31'd0, oIdle}, 32'd1);

    // T6: random pushes against random ready stalls, wrapping the pointers
    drv_maxlow = 4;
    pushed = 0;
    cyc = 0;
    s0 = strobes;
    while (pushed < 40 && cyc < 5000) begin
      if ($urandom_range(1, 0) == 1 && exp_q.size() < 15) begin
        iWrite = 1'b1;
        iData  = 8'($urandom);
        exp_q.push_back(iData);
        pushed++;
      end else begin
        iWrite = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    iWrite = 1'b0;
    check("t6_all_pushed", pushed, 32'd40);
    drain("t6_drain");
    check("t6_strobes", strobes - s0, 32'd40);
    check("t6_empty", {31'd0, oEmpty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
